moonbase_bus_responder: RTL and testbench

Bus-side companion for the moonbase 4-bit CPU's multiplexed 8-bit external bus. It emulates the external 7-bit address latch, a 256-nibble SRAM split into code and data halves, and a small device port. It also provides a preload port for writing program images. It sits at the top level, directly opposite the CPU: its bus input carries the CPU's bus output, and its bus output feeds the CPU's bus input.

---
 rtl/moonbase_bus_pkg.sv | 21 ++
 rtl/moonbase_nibble_ram.sv | 25 ++
 rtl/moonbase_bus_responder.sv | 105 ++++++++++
 tb/tb_moonbase_bus_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/moonbase_bus_pkg.sv
// Shared constants for the moonbase external-bus responder: bus bit positions,
// memory geometry and space encoding.
package moonbase_bus_pkg;

   localparam logic [2:0] STB      = 3'd7;
   localparam logic [2:0] SPACE    = 3'd6;
   localparam logic [2:0] WR_RAM_N = 3'd5;
   localparam logic [2:0] WR_DEV_N = 3'd4;

   localparam int MEM_DEPTH = 256;
   localparam int ADDR_W    = 7;

   localparam logic SPACE_CODE = 1'b1;
   localparam logic SPACE_DATA = 1'b0;

   // A write enable is only meaningful in a non-strobe cycle; enables are active-low.
   function automatic logic bus_wr_req(input logic [7:0] bus, input logic [2:0] bit_pos);
      return ~bus[STB] & ~bus[bit_pos];
   endfunction

endpackage

// File: rtl/moonbase_nibble_ram.sv
// 256x4 nibble SRAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so preloaded images survive CPU reset.
module moonbase_nibble_ram
   import moonbase_bus_pkg::*;
(
   input  logic       clk,
   input  logic       we_i,
   input  logic [7:0] waddr_i,
   input  logic [3:0] wdata_i,
   input  logic [7:0] raddr_i,
   output logic [3:0] rdata_o
);

   logic [3:0] mem_q [MEM_DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/moonbase_bus_responder.sv
// Bus responder opposite the moonbase CPU: address latch, nibble SRAM with
// preload port, and a small device register / device input port.
module moonbase_bus_responder
   import moonbase_bus_pkg::*;
#(
   parameter int N_DEV_OUT = 8,
   parameter int N_DEV_IN  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             bus_in,
   output logic [7:0]             bus_out,
   input  logic [2*N_DEV_IN-1:0]  dev_in,
   output logic [4*N_DEV_OUT-1:0] dev_out,
   output logic                   dev_wr,
   output logic [2:0]             dev_waddr,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [7:0]             load_addr,
   input  logic [3:0]             load_data,
   output logic [ADDR_W-1:0]      latch_q
);

   logic              cpu_wr_ram_s;
   logic              cpu_wr_dev_s;
   logic [7:0]        ram_addr_s;
   logic [3:0]        ram_rdata_s;
   logic              ram_we_s;
   logic [7:0]        ram_waddr_s;
   logic [3:0]        ram_wdata_s;
   logic [1:0]        dev_field_s;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        dev_q [N_DEV_OUT];
   logic [3:0]        dev_d [N_DEV_OUT];
   logic              dev_wr_q, dev_wr_d;
   logic [2:0]        dev_waddr_q, dev_waddr_d;

   assign cpu_wr_ram_s = bus_wr_req(bus_in, WR_RAM_N) & ~reset;
   assign cpu_wr_dev_s = bus_wr_req(bus_in, WR_DEV_N) & ~reset;
   assign ram_addr_s   = {bus_in[SPACE], addr_q};

   // The CPU owns the write port whenever it writes; the loader is stalled then.
   assign load_ready  = ~cpu_wr_ram_s;
   assign ram_we_s    = cpu_wr_ram_s | load_valid;
   assign ram_waddr_s = cpu_wr_ram_s ? ram_addr_s : load_addr;
   assign ram_wdata_s = cpu_wr_ram_s ? bus_in[3:0] : load_data;

   moonbase_nibble_ram u_ram (
      .clk     (clk),
      .we_i    (ram_we_s),
      .waddr_i (ram_waddr_s),
      .wdata_i (ram_wdata_s),
      .raddr_i (ram_addr_s),
      .rdata_o (ram_rdata_s)
   );

   assign dev_field_s = dev_in[{addr_q[1:0], 1'b0} +: 2];
   assign bus_out     = {dev_field_s, ram_rdata_s, 2'b00};

   // Next-state for latch, device registers and the write-notify pulse.
   always_comb begin
      addr_d      = addr_q;
      dev_d       = dev_q;
      dev_wr_d    = 1'b0;
      dev_waddr_d = dev_waddr_q;
      if (reset) begin
         addr_d      = '0;
         dev_waddr_d = 3'd0;
         for (int k = 0; k < N_DEV_OUT; k++) begin
            dev_d[k] = 4'h0;
         end
      end else begin
         if (bus_in[STB]) begin
            addr_d = bus_in[ADDR_W-1:0];
         end else begin
            addr_d = addr_q;
         end
         if (cpu_wr_dev_s) begin
            dev_d[addr_q[2:0]] = bus_in[3:0];
            dev_wr_d           = 1'b1;
            dev_waddr_d        = addr_q[2:0];
         end else begin
            dev_wr_d = 1'b0;
         end
      end
   end

   // State registers; reset is folded into the next-state logic.
   always_ff @(posedge clk) begin
      addr_q      <= addr_d;
      dev_q       <= dev_d;
      dev_wr_q    <= dev_wr_d;
      dev_waddr_q <= dev_waddr_d;
   end

   for (genvar g = 0; g < N_DEV_OUT; g++) begin : g_dev_out
      assign dev_out[4*g +: 4] = dev_q[g];
   end

   assign dev_wr    = dev_wr_q;
   assign dev_waddr = dev_waddr_q;
   assign latch_q   = addr_q;

endmodule

// File: tb/tb_moonbase_bus_responder.sv
// Self-checking bench for moonbase_bus_responder: directed scenarios plus
// randomized traffic against a behavioural memory/latch/device model.
module tb_moonbase_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  bus_in;
   logic [7:0]  bus_out;
   logic [7:0]  dev_in;
   logic [31:0] dev_out;
   logic        dev_wr;
   logic [2:0]  dev_waddr;
   logic        load_valid;
   logic        load_ready;
   logic [7:0]  load_addr;
   logic [3:0]  load_data;
   logic [6:0]  latch_q;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [3:0] m_mem   [256];
   bit         m_known [256];
   logic [6:0] m_latch;
   logic [3:0] m_dev   [8];
   logic       m_dev_wr;
   logic [2:0] m_dev_waddr;

   moonbase_bus_responder #(.N_DEV_OUT(8), .N_DEV_IN(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus_in     (bus_in),
      .bus_out    (bus_out),
      .dev_in     (dev_in),
      .dev_out    (dev_out),
      .dev_wr     (dev_wr),
      .dev_waddr  (dev_waddr),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .latch_q    (latch_q)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_dev_vec();
      logic [31:0] v;
      for (int k = 0; k < 8; k++) v[4*k +: 4] = m_dev[k];
      return v;
   endfunction

   function automatic logic m_ready();
      return !(reset == 1'b0 && bus_in[7] == 1'b0 && bus_in[5] == 1'b0);
   endfunction

   // Apply inputs for the coming cycle and let combinational outputs settle.
   task automatic apply(input logic rst, input logic [7:0] bus,
                        input logic lv, input logic [7:0] la, input logic [3:0] ld);
      reset = rst; bus_in = bus; load_valid = lv; load_addr = la; load_data = ld;
      #1;
   endtask

   // Clock edge: advance the model from the inputs held through this cycle.
   task automatic tick();
      bit         cw_ram, cw_dev;
      logic [7:0] ra;
      cw_ram = !reset && !bus_in[7] && !bus_in[5];
      cw_dev = !reset && !bus_in[7] && !bus_in[4];
      ra     = {bus_in[6], m_latch};
      @(posedge clk);
      if (cw_ram) begin
         m_mem[ra] = bus_in[3:0]; m_known[ra] = 1'b1;
      end else if (load_valid) begin
         m_mem[load_addr] = load_data; m_known[load_addr] = 1'b1;
      end
      if (reset) begin
         m_latch = 7'd0; m_dev_wr = 1'b0; m_dev_waddr = 3'd0;
         for (int k = 0; k < 8; k++) m_dev[k] = 4'h0;
      end else begin
         m_dev_wr = cw_dev;
         if (cw_dev) begin
            m_dev[m_latch[2:0]] = bus_in[3:0];
            m_dev_waddr = m_latch[2:0];
         end
         if (bus_in[7]) m_latch = bus_in[6:0];
      end
      #1;
   endtask

   task automatic test_reset();
      dev_in = 8'h00;
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 8'h00, 1'b0, 8'h00, 4'h0);
         n_tests++;
         if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", load_ready); end
         tick();
      end
      n_tests++;
      if (latch_q !== 7'h00) begin n_fail++; $display("FAIL reset_latch got %h want 00", latch_q); end
      n_tests++;
      if (dev_out !== 32'h0) begin n_fail++; $display("FAIL reset_devout got %h want 0", dev_out); end
      n_tests++;
      if (dev_wr !== 1'b0 || dev_waddr !== 3'd0) begin
         n_fail++; $display("FAIL reset_devwr got %b/%0d want 0/0", dev_wr, dev_waddr);
      end
   endtask

   task automatic test_loader_read();
      dev_in = 8'h00;
      apply(1'b0, 8'h70, 1'b1, 8'h85, 4'hA);
      n_tests++;
      if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_idle got %b want 1", load_ready); end
      tick();
      apply(1'b0, 8'h85, 1'b0, 8'h00, 4'h0); tick();
      apply(1'b0, 8'h70, 1'b0, 8'h00, 4'h0);
      n_tests++;
      if (latch_q !== 7'h05) begin n_fail++; $display("FAIL loader_latch got %h want 05", latch_q); end
      n_tests++;
      if (bus_out !== 8'h28) begin n_fail++; $display("FAIL loader_read got %h want 28", bus_out); end
      tick();
   endtask

   task automatic test_cpu_ram_write();
      logic [31:0] dev_before;
      dev_before = dev_out;
      apply(1'b0, 8'h92, 1'b0, 8'h00, 4'h0); tick();
      apply(1'b0, 8'h1B, 1'b0, 8'h00, 4'h0);
      n_tests++;
      if (load_ready !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_ready got %b want 0", load_ready); end
      tick();
      n_tests++;
      if (dev_out !== dev_before || dev_wr !== 1'b0) begin
         n_fail++; $display("FAIL cpu_wr_dev_side got %h/%b want %h/0", dev_out, dev_wr, dev_before);
      end
      apply(1'b0, 8'h30, 1'b0, 8'h00, 4'h0);
      n_tests++;
      if (bus_out[5:2] !== 4'hB) begin n_fail++; $display("FAIL cpu_wr_read got %h want b", bus_out[5:2]); end
      tick();
   endtask

   task automatic test_dev_write();
      apply(1'b0, 8'h30, 1'b1, 8'h03, 4'h9); tick();
      apply(1'b0, 8'h83, 1'b0, 8'h00, 4'h0); tick();
      apply(1'b0, 8'h27, 1'b0, 8'h00, 4'h0);
      n_tests++;
      if (load_ready !== 1'b1) begin n_fail++; $display("FAIL dev_wr_ready got %b want 1", load_ready); end
      tick();
      n_tests++;
      if (dev_out[15:12] !== 4'h7) begin n_fail++; $display("FAIL dev_wr_data got %h want 7", dev_out[15:12]); end
      n_tests++;
      if (dev_wr !== 1'b1 || dev_waddr !== 3'd3) begin
         n_fail++; $display("FAIL dev_wr_pulse got %b/%0d want 1/3", dev_wr, dev_waddr);
      end
      apply(1'b0, 8'h30, 1'b0, 8'h00, 4'h0);
      n_tests++;
      if (bus_out[5:2] !== 4'h9) begin n_fail++; $display("FAIL dev_wr_ram got %h want 9", bus_out[5:2]); end
      tick();
      n_tests++;
      if (dev_wr !== 1'b0) begin n_fail++; $display("FAIL dev_wr_one_cycle got %b want 0", dev_wr); end
   endtask

   task automatic test_dev_read();
      dev_in = 8'b10_01_11_00;
      apply(1'b0, 8'h82, 1'b0, 8'h00, 4'h0); tick();
      apply(1'b0, 8'h70, 1'b0, 8'h00, 4'h0);
      n_tests++;
      if (bus_out[7:6] !== 2'b01) begin n_fail++; $display("FAIL dev_read got %b want 01", bus_out[7:6]); end
      tick();
      dev_in = 8'h00;
   endtask

   task automatic test_preload_in_reset();
      logic [7:0] bus;
      apply(1'b1, 8'h30, 1'b1, 8'h00, 4'h6); tick();
      for (int i = 0; i < 16; i++) begin
         bus = (i == 7) ? 8'h0F : 8'h30;
         apply(1'b1, bus, 1'b1, 8'h80 + 8'(i), 4'(i));
         n_tests++;
         if (load_ready !== 1'b1) begin n_fail++; $display("FAIL preload_stall idx %0d got %b want 1", i, load_ready); end
         tick();
      end
      n_tests++;
      if (dev_out !== 32'h0 || latch_q !== 7'h00) begin
         n_fail++; $display("FAIL preload_state got %h/%h want 0/0", dev_out, latch_q);
      end
      apply(1'b0, 8'h30, 1'b0, 8'h00, 4'h0);
      n_tests++;
      if (bus_out[5:2] !== 4'h6) begin n_fail++; $display("FAIL preload_no_cpu_wr got %h want 6", bus_out[5:2]); end
      tick();
      for (int i = 0; i < 16; i++) begin
         apply(1'b0, 8'h80 | 8'(i), 1'b0, 8'h00, 4'h0); tick();
         apply(1'b0, 8'h70, 1'b0, 8'h00, 4'h0);
         n_tests++;
         if (bus_out[5:2] !== 4'(i)) begin
            n_fail++; $display("FAIL preload_read idx %0d got %h want %h", i, bus_out[5:2], 4'(i));
         end
         tick();
      end
   endtask

   task automatic test_collision();
      apply(1'b0, 8'hA0, 1'b0, 8'h00, 4'h0); tick();
      apply(1'b0, 8'h15, 1'b1, 8'h20, 4'hC);
      n_tests++;
      if (load_ready !== 1'b0) begin n_fail++; $display("FAIL collide_ready got %b want 0", load_ready); end
      tick();
      apply(1'b0, 8'h30, 1'b1, 8'h20, 4'hC);
      n_tests++;
      if (load_ready !== 1'b1) begin n_fail++; $display("FAIL collide_ready2 got %b want 1", load_ready); end
      n_tests++;
      if (bus_out[5:2] !== 4'h5) begin n_fail++; $display("FAIL collide_cpu got %h want 5", bus_out[5:2]); end
      tick();
      apply(1'b0, 8'h30, 1'b0, 8'h00, 4'h0);
      n_tests++;
      if (bus_out[5:2] !== 4'hC) begin n_fail++; $display("FAIL collide_load got %h want c", bus_out[5:2]); end
      tick();
   endtask

   task automatic test_random();
      logic [7:0] ra;
      logic [1:0] fld;
      for (int i = 0; i < 400; i++) begin
         dev_in = 8'($urandom);
         apply(($urandom_range(0, 19) == 0) && (i < 390), 8'($urandom),
               1'($urandom), 8'($urandom), 4'($urandom));
         ra  = {bus_in[6], m_latch};
         fld = 2'((dev_in >> (2 * m_latch[1:0])) & 8'h03);
         n_tests++;
         if (load_ready !== m_ready()) begin
            n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, load_ready, m_ready());
         end
         n_tests++;
         if (m_known[ra] && bus_out !== {fld, m_mem[ra], 2'b00}) begin
            n_fail++; $display("FAIL rnd_bus_out cyc %0d got %h want %h", i, bus_out, {fld, m_mem[ra], 2'b00});
         end else if (!m_known[ra] && {bus_out[7:6], bus_out[1:0]} !== {fld, 2'b00}) begin
            n_fail++; $display("FAIL rnd_bus_dev cyc %0d got %h want %b00", i, bus_out, fld);
         end
         tick();
         n_tests++;
         if (latch_q !== m_latch || dev_out !== m_dev_vec()) begin
            n_fail++; $display("FAIL rnd_state cyc %0d got %h/%h want %h/%h", i, latch_q, dev_out, m_latch, m_dev_vec());
         end
         n_tests++;
         if (dev_wr !== m_dev_wr || (m_dev_wr && dev_waddr !== m_dev_waddr)) begin
            n_fail++; $display("FAIL rnd_devwr cyc %0d got %b/%0d want %b/%0d", i, dev_wr, dev_waddr, m_dev_wr, m_dev_waddr);
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin m_mem[a] = 4'h0; m_known[a] = 1'b0; end
      for (int k = 0; k < 8; k++) m_dev[k] = 4'h0;
      m_latch = 7'd0; m_dev_wr = 1'b0; m_dev_waddr = 3'd0;
      dev_in = 8'h00;
      @(posedge clk); #1;
      test_reset();
      test_loader_read();
      test_cpu_ram_write();
      test_dev_write();
      test_dev_read();
      test_preload_in_reset();
      test_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
